mem_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction and data cache miss paths of CORES pipelines.

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

    localparam int unsigned DEF_CORES  = 2;
    localparam int unsigned ARB_CORE_W = (DEF_CORES > 1) ? $clog2(DEF_CORES) : 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [2*N-1:0] w_rot;
    logic [W:0]     w_sum;

    // Rotate so bit 0 is the ptr position; the first hit's offset is then added back mod N.
    always_comb begin
        w_rot   = {req, req} >> ptr;
        w_sum   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && w_rot[i]) begin
                any     = 1'b1;
                w_sum   = {1'b0, ptr} + (W+1)'(i);
                gnt_idx = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port shared by per-core icache/dcache miss paths; dcache has priority,
// round-robin within each class, dcache bursts held, icache starvation bounded.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CORES       = 2,
    parameter int unsigned BURST_WORDS = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CORES-1:0]    iREN,
    input  logic [CORES*32-1:0] iaddr,
    output logic [CORES-1:0]    iwait,
    output logic [CORES*32-1:0] iload,
    input  logic [CORES-1:0]    dREN,
    input  logic [CORES-1:0]    dWEN,
    input  logic [CORES*32-1:0] daddr,
    input  logic [CORES*32-1:0] dstore,
    output logic [CORES-1:0]    dwait,
    output logic [CORES*32-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  ramstate_t         ramstate
);

    localparam int unsigned CW  = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int unsigned BCW = $clog2(BURST_WORDS + 1);
    localparam int unsigned SCW = $clog2(CORES + 1);

    arb_state_t     r_state;
    logic [CW-1:0]  r_owner;
    logic [CW-1:0]  r_rr_i;
    logic [CW-1:0]  r_rr_d;
    logic [BCW-1:0] r_burst_cnt;
    logic [SCW-1:0] r_skip_cnt [CORES];

    logic [31:0]      w_iaddr  [CORES];
    logic [31:0]      w_daddr  [CORES];
    logic [31:0]      w_dstore [CORES];
    logic [CORES-1:0] w_dreq;
    logic [CORES-1:0] w_starved;
    logic [CORES-1:0] w_ireq_sel;
    logic [CW-1:0]    w_i_gnt;
    logic [CW-1:0]    w_d_gnt;
    logic             w_i_any;
    logic             w_d_any;
    logic [CW-1:0]    w_owner_inc;
    logic [BCW-1:0]   w_burst_next;
    logic             w_burst_done;
    logic             w_access;
    logic             w_error;

    always_comb begin
        for (int unsigned c = 0; c < CORES; c++) begin
            w_iaddr[c]   = iaddr[c*32 +: 32];
            w_daddr[c]   = daddr[c*32 +: 32];
            w_dstore[c]  = dstore[c*32 +: 32];
            w_starved[c] = iREN[c] && (r_skip_cnt[c] == SCW'(CORES));
        end
    end

    assign w_dreq       = dREN | dWEN;
    assign w_ireq_sel   = (|w_starved) ? w_starved : iREN;
    assign w_access     = (ramstate == ACCESS);
    assign w_error      = (ramstate == ERROR);
    assign w_owner_inc  = (32'(r_owner) + 1 >= CORES) ? '0 : r_owner + 1'b1;
    assign w_burst_next = r_burst_cnt + 1'b1;
    assign w_burst_done = (32'(w_burst_next) >= BURST_WORDS);

    rr_arbiter #(.N(CORES), .W(CW)) u_rr_i (
        .req     (w_ireq_sel),
        .ptr     (r_rr_i),
        .gnt_idx (w_i_gnt),
        .any     (w_i_any)
    );

    rr_arbiter #(.N(CORES), .W(CW)) u_rr_d (
        .req     (w_dreq),
        .ptr     (r_rr_d),
        .gnt_idx (w_d_gnt),
        .any     (w_d_any)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_i      <= '0;
            r_rr_d      <= '0;
            r_burst_cnt <= '0;
            for (int unsigned c = 0; c < CORES; c++) begin
                r_skip_cnt[c] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_starved) begin
                        r_state <= IGRANT;
                        r_owner <= w_i_gnt;
                    end else if (w_d_any) begin
                        r_state     <= DGRANT;
                        r_owner     <= w_d_gnt;
                        r_burst_cnt <= '0;
                        // Every icache passed over by this burst moves one step toward a forced grant.
                        for (int unsigned c = 0; c < CORES; c++) begin
                            if (iREN[c] && (r_skip_cnt[c] != SCW'(CORES))) begin
                                r_skip_cnt[c] <= r_skip_cnt[c] + 1'b1;
                            end
                        end
                    end else if (w_i_any) begin
                        r_state <= IGRANT;
                        r_owner <= w_i_gnt;
                    end
                end
                IGRANT: begin
                    if (!iREN[r_owner]) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_state             <= IDLE;
                        r_rr_i              <= w_owner_inc;
                        r_skip_cnt[r_owner] <= '0;
                    end else if (w_error) begin
                        r_state <= IDLE;
                    end
                end
                DGRANT: begin
                    if (!w_dreq[r_owner]) begin
                        r_state <= IDLE;
                        r_rr_d  <= w_owner_inc;
                    end else if (w_error) begin
                        r_state <= IDLE;
                    end else if (w_access) begin
                        r_burst_cnt <= w_burst_next;
                        if (w_burst_done) begin
                            r_state <= IDLE;
                            r_rr_d  <= w_owner_inc;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (r_state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = w_iaddr[r_owner];
                if (w_access) iwait[r_owner] = 1'b0;
            end
            DGRANT: begin
                ramWEN   = dWEN[r_owner];
                ramREN   = dREN[r_owner] & ~dWEN[r_owner];
                ramaddr  = w_daddr[r_owner];
                ramstore = w_dstore[r_owner];
                if (w_access) dwait[r_owner] = 1'b0;
            end
            default: ;
        endcase
    end

    assign iload = {CORES{ramload}};
    assign dload = {CORES{ramload}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, async reset check,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int N  = 2;
    localparam int BW = 2;
    localparam logic [31:0] S0 = 32'h5A5A0000;
    localparam logic [31:0] S1 = 32'hC0DE0001;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [N-1:0]    iREN, dREN, dWEN, iwait, dwait;
    logic [N*32-1:0] iaddr, daddr, dstore, iload, dload;
    logic            ramREN, ramWEN;
    logic [31:0]     ramaddr, ramstore, ramload;
    ramstate_t       ramstate;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.CORES(N), .BURST_WORDS(BW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen;
        logic [31:0] daddr1;
        ramstate_t   rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
    } vec_t;

    vec_t vt[$];

    task automatic v(input logic rst, input logic [1:0] ir, input logic [1:0] dr,
                     input logic [1:0] dwn, input logic [31:0] a1, input ramstate_t rs,
                     input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] store, input logic [1:0] iw, input logic [1:0] dw);
        vec_t r;
        r.rst = rst; r.iren = ir; r.dren = dr; r.dwen = dwn; r.daddr1 = a1; r.rs = rs;
        r.ren = ren; r.wen = wen; r.addr = addr; r.store = store; r.iw = iw; r.dw = dw;
        vt.push_back(r);
    endtask

    // Row whose expected outputs are the idle bus with every wait asserted.
    task automatic vi(input logic rst, input logic [1:0] ir, input logic [1:0] dr,
                      input logic [1:0] dwn, input ramstate_t rs);
        v(rst, ir, dr, dwn, 32'h300, rs, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11);
    endtask

    // Reference model: who holds the RAM, words moved, fairness pointers, pass-over counts.
    int m_kind;   // 0 none, 1 icache, 2 dcache
    int m_core, m_words, m_ptr_i, m_ptr_d;
    int m_skip [N];

    task automatic model_reset();
        m_kind = 0; m_core = 0; m_words = 0; m_ptr_i = 0; m_ptr_d = 0;
        for (int c = 0; c < N; c++) m_skip[c] = 0;
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int from);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (from + k) % N;
            if (mask[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [31:0] word(input logic [N*32-1:0] vec, input int c);
        return vec[c*32 +: 32];
    endfunction

    task automatic model_expect(output logic [65:0] eb, output logic [3:0] ew);
        logic [1:0] iw, dw;
        iw = '1; dw = '1; eb = '0;
        if (nRST && m_kind == 1) begin
            eb = {1'b1, 1'b0, word(iaddr, m_core), 32'h0};
            if (ramstate == ACCESS) iw[m_core] = 1'b0;
        end else if (nRST && m_kind == 2) begin
            eb = {dREN[m_core] & ~dWEN[m_core], dWEN[m_core], word(daddr, m_core), word(dstore, m_core)};
            if (ramstate == ACCESS) dw[m_core] = 1'b0;
        end
        ew = {iw, dw};
    endtask

    task automatic model_advance();
        logic [N-1:0] starved, dreq;
        dreq = dREN | dWEN;
        if (!nRST) begin
            model_reset();
        end else if (m_kind == 0) begin
            for (int c = 0; c < N; c++) starved[c] = iREN[c] && (m_skip[c] >= N);
            if (starved != 0) begin
                m_kind = 1; m_core = pick(starved, m_ptr_i);
            end else if (dreq != 0) begin
                m_kind = 2; m_core = pick(dreq, m_ptr_d); m_words = 0;
                for (int c = 0; c < N; c++) if (iREN[c] && m_skip[c] < N) m_skip[c]++;
            end else if (iREN != 0) begin
                m_kind = 1; m_core = pick(iREN, m_ptr_i);
            end
        end else if (m_kind == 1) begin
            if (!iREN[m_core]) m_kind = 0;
            else if (ramstate == ACCESS) begin
                m_kind = 0; m_ptr_i = (m_core + 1) % N; m_skip[m_core] = 0;
            end else if (ramstate == ERROR) m_kind = 0;
        end else begin
            if (!dreq[m_core]) begin
                m_kind = 0; m_ptr_d = (m_core + 1) % N;
            end else if (ramstate == ERROR) m_kind = 0;
            else if (ramstate == ACCESS) begin
                m_words++;
                if (m_words >= BW) begin
                    m_kind = 0; m_ptr_d = (m_core + 1) % N;
                end
            end
        end
    endtask

    initial begin
        logic [65:0] eb;
        logic [3:0]  ew;
        int r;

        // Reset held with every request high, then the first grant appears only after release.
        vi(0, 2'b11, 2'b11, 2'b00, FREE);
        vi(0, 2'b11, 2'b11, 2'b00, FREE);
        vi(1, 2'b11, 2'b11, 2'b00, FREE);
        v (1, 2'b11, 2'b11, 2'b00, 32'h300, BUSY,   1, 0, 32'h200, S0, 2'b11, 2'b11);
        // icache 0 read at 0x40, ACCESS two cycles after the request.
        vi(0, 2'b00, 2'b00, 2'b00, FREE);
        vi(1, 2'b01, 2'b00, 2'b00, FREE);
        v (1, 2'b01, 2'b00, 2'b00, 32'h300, BUSY,   1, 0, 32'h40,  0,  2'b11, 2'b11);
        v (1, 2'b01, 2'b00, 2'b00, 32'h300, ACCESS, 1, 0, 32'h40,  0,  2'b10, 2'b11);
        vi(1, 2'b00, 2'b00, 2'b00, FREE);
        // icache 1 and dcache 0 together: dcache first, icache 1 next.
        vi(0, 2'b00, 2'b00, 2'b00, FREE);
        vi(1, 2'b10, 2'b01, 2'b00, FREE);
        v (1, 2'b10, 2'b01, 2'b00, 32'h300, ACCESS, 1, 0, 32'h200, S0, 2'b11, 2'b10);
        v (1, 2'b10, 2'b00, 2'b00, 32'h300, FREE,   0, 0, 32'h200, S0, 2'b11, 2'b11);
        vi(1, 2'b10, 2'b00, 2'b00, FREE);
        v (1, 2'b10, 2'b00, 2'b00, 32'h300, ACCESS, 1, 0, 32'h80,  0,  2'b01, 2'b11);
        vi(1, 2'b00, 2'b00, 2'b00, FREE);
        // dcache 1 two-word write-back, icache 0 waiting behind it.
        vi(0, 2'b00, 2'b00, 2'b00, FREE);
        v (1, 2'b01, 2'b00, 2'b10, 32'h100, FREE,   0, 0, 32'h0,   0,  2'b11, 2'b11);
        v (1, 2'b01, 2'b00, 2'b10, 32'h100, ACCESS, 0, 1, 32'h100, S1, 2'b11, 2'b01);
        v (1, 2'b01, 2'b00, 2'b10, 32'h104, ACCESS, 0, 1, 32'h104, S1, 2'b11, 2'b01);
        vi(1, 2'b01, 2'b00, 2'b00, FREE);
        v (1, 2'b01, 2'b00, 2'b00, 32'h300, ACCESS, 1, 0, 32'h40,  0,  2'b10, 2'b11);
        // Both dcaches streaming: bursts alternate and icache 0 is forced in after two.
        vi(0, 2'b00, 2'b00, 2'b00, FREE);
        vi(1, 2'b01, 2'b11, 2'b00, FREE);
        v (1, 2'b01, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h200, S0, 2'b11, 2'b10);
        v (1, 2'b01, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h200, S0, 2'b11, 2'b10);
        vi(1, 2'b01, 2'b11, 2'b00, FREE);
        v (1, 2'b01, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h300, S1, 2'b11, 2'b01);
        v (1, 2'b01, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h300, S1, 2'b11, 2'b01);
        vi(1, 2'b01, 2'b11, 2'b00, FREE);
        v (1, 2'b01, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h40,  0,  2'b10, 2'b11);
        vi(1, 2'b00, 2'b11, 2'b00, FREE);
        v (1, 2'b00, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h200, S0, 2'b11, 2'b10);
        // ERROR during dcache 0 grant: no completion, same core regranted, then reset mid-burst.
        vi(0, 2'b00, 2'b00, 2'b00, FREE);
        vi(1, 2'b00, 2'b11, 2'b00, FREE);
        v (1, 2'b00, 2'b11, 2'b00, 32'h300, ERROR,  1, 0, 32'h200, S0, 2'b11, 2'b11);
        vi(1, 2'b00, 2'b11, 2'b00, FREE);
        v (1, 2'b00, 2'b11, 2'b00, 32'h300, ACCESS, 1, 0, 32'h200, S0, 2'b11, 2'b10);
        v (1, 2'b00, 2'b11, 2'b00, 32'h300, BUSY,   1, 0, 32'h200, S0, 2'b11, 2'b11);
        vi(0, 2'b00, 2'b11, 2'b00, FREE);

        iaddr   = {32'h80, 32'h40};
        dstore  = {S1, S0};
        ramload = 32'hDEADBEEF;

        for (int i = 0; i < vt.size(); i++) begin
            nRST = vt[i].rst; iREN = vt[i].iren; dREN = vt[i].dren; dWEN = vt[i].dwen;
            daddr = {vt[i].daddr1, 32'h200}; ramstate = vt[i].rs;
            @(negedge CLK);
            check($sformatf("row%0d_bus", i), {ramREN, ramWEN, ramaddr, ramstore},
                  {vt[i].ren, vt[i].wen, vt[i].addr, vt[i].store});
            check($sformatf("row%0d_waits", i), {iwait, dwait}, {vt[i].iw, vt[i].dw});
            check($sformatf("row%0d_iload", i), iload, {2{32'hDEADBEEF}});
            @(posedge CLK); #1;
        end

        // Asynchronous reset in the middle of a grant clears the bus without a clock edge.
        nRST = 1'b1; iREN = '0; dREN = 2'b01; dWEN = '0; ramstate = BUSY;
        @(posedge CLK); #1;
        @(posedge CLK); #3;
        check("grant_before_rst", {ramREN, ramWEN, ramaddr, ramstore}, {1'b1, 1'b0, 32'h200, S0});
        nRST = 1'b0;
        #1;
        check("async_rst_bus", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
        check("async_rst_waits", {iwait, dwait}, 4'hF);
        @(posedge CLK); #1;

        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nRST = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < N; c++) begin
                iREN[c] = ($urandom_range(0, 9) < 4);
                dREN[c] = ($urandom_range(0, 9) < 3);
                dWEN[c] = ($urandom_range(0, 9) < 2);
            end
            iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom}; ramload = $urandom;
            r = $urandom_range(0, 9);
            ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
            @(negedge CLK);
            model_expect(eb, ew);
            check($sformatf("rnd%0d_bus", cyc), {ramREN, ramWEN, ramaddr, ramstore}, eb);
            check($sformatf("rnd%0d_waits", cyc), {iwait, dwait}, ew);
            check($sformatf("rnd%0d_loads", cyc), {iload, dload}, {4{ramload}});
            model_advance();
            @(posedge CLK); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
